// File: rtl/wfq_req_initiator.sv
// WFQ rank-calculation initiator.
// Takes enqueue descriptors, divides packet length by the per-class weight
// with a serial restoring divider, hands quotient/remainder to the WFQ rank
// engine, and forwards the engine's rank (with the buffer address spliced in)
// to the PIFO insert port.
//
// Handshakes: pkt_valid/pkt_ready and rank_valid/rank_ready are strict
// valid/ready pairs -- a transfer happens on a rising clk edge where both are
// high; a producer holding valid keeps its payload stable until that edge.
// req_valid is a single-cycle pulse with no back-pressure, and resp_valid is
// a strobe that is only honoured while waiting for the engine.
module wfq_req_initiator #(
  parameter int CLASS_WIDTH         = 5,
  parameter int WEIGHT_WIDTH        = 16,
  parameter int PKT_WIDTH           = 16,
  parameter int RESULT_WIDTH        = 32,
  parameter int PIFO_OVERFLOW_WIDTH = 1,
  parameter int PIFO_ROUND_WIDTH    = 18,
  parameter int PIFO_ADDR_WIDTH     = 12,
  parameter int RESP_TIMEOUT        = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  // descriptor input
  input  logic                       pkt_valid,
  output logic                       pkt_ready,
  input  logic [CLASS_WIDTH-1:0]     pkt_class_id,
  input  logic [PKT_WIDTH-1:0]       pkt_len,
  input  logic [PIFO_ADDR_WIDTH-1:0] pkt_addr,
  // weight table configuration
  input  logic                       cfg_wr_en,
  input  logic [CLASS_WIDTH-1:0]     cfg_class_id,
  input  logic [WEIGHT_WIDTH-1:0]    cfg_weight,
  // rank engine request
  output logic                       req_valid,
  output logic [CLASS_WIDTH-1:0]     req_class_id,
  output logic [WEIGHT_WIDTH-1:0]    req_div_quotient,
  output logic [WEIGHT_WIDTH-1:0]    req_div_remain,
  // rank engine response
  input  logic                       resp_valid,
  input  logic [RESULT_WIDTH-1:0]    resp_data,
  // PIFO insert port
  output logic                       rank_valid,
  input  logic                       rank_ready,
  output logic [RESULT_WIDTH-1:0]    rank_data,
  // status / debug
  output logic                       err_timeout,
  output logic [2:0]                 dbg_state
);

  localparam int CLASS_ID_COUNT = 2 ** CLASS_WIDTH;
  localparam int CNT_W          = $clog2(PKT_WIDTH + 1);
  localparam int TO_W           = $clog2(RESP_TIMEOUT + 1);
  // rank bits returned by the engine: {valid-marker, overflow, round}
  localparam int RANK_HI_W      = 1 + PIFO_OVERFLOW_WIDTH + PIFO_ROUND_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DIV   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_e;

  state_e state_q, state_d;

  // weight table
  logic [WEIGHT_WIDTH-1:0]    weight_q [CLASS_ID_COUNT];

  // descriptor / divider working registers
  logic [CLASS_WIDTH-1:0]     class_q, class_d;
  logic [PKT_WIDTH-1:0]       len_q, len_d;
  logic [PIFO_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WEIGHT_WIDTH-1:0]    wt_q, wt_d;
  logic [PKT_WIDTH-1:0]       quot_q, quot_d;
  logic [WEIGHT_WIDTH-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  // request / response / status registers
  logic [CLASS_WIDTH-1:0]     req_class_q, req_class_d;
  logic [WEIGHT_WIDTH-1:0]    req_quot_q, req_quot_d;
  logic [WEIGHT_WIDTH-1:0]    req_rem_q, req_rem_d;
  logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
  logic                       err_q, err_d;
  logic [RESULT_WIDTH-1:0]    rank_q, rank_d;

  // divider step signals
  logic [WEIGHT_WIDTH:0]      trial;
  logic [WEIGHT_WIDTH:0]      diff;
  logic                       trial_ge;
  logic                       div_last;
  logic                       timeout_hit;
  logic [WEIGHT_WIDTH-1:0]    wt_lookup;

  // the engine's copy of the address is not used; ours is authoritative
  logic [PIFO_ADDR_WIDTH-1:0] unused_resp_addr;
  assign unused_resp_addr = resp_data[PIFO_ADDR_WIDTH-1:0];

  // One restoring step: shift in the next dividend bit and try to subtract.
  assign trial       = {rem_q, len_q[PKT_WIDTH-1]};
  assign diff        = trial - {1'b0, wt_q};
  assign trial_ge    = (trial >= {1'b0, wt_q});
  assign div_last    = (cnt_q == CNT_W'(1));
  assign timeout_hit = !resp_valid && (to_cnt_q == TO_W'(RESP_TIMEOUT - 1));
  // a zero weight would make the division meaningless, so treat it as 1
  assign wt_lookup   = (weight_q[pkt_class_id] == '0) ? WEIGHT_WIDTH'(1)
                                                      : weight_q[pkt_class_id];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pkt_valid) state_d = S_DIV;
      S_DIV:   if (div_last) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (resp_valid)       state_d = S_OUT;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_OUT:   if (rank_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM-decoded outputs; pkt_ready stays low while reset is held
  always_comb begin
    pkt_ready  = (state_q == S_IDLE) && !rst;
    req_valid  = (state_q == S_ISSUE);
    rank_valid = (state_q == S_OUT);
    dbg_state  = state_q;
  end

  assign req_class_id     = req_class_q;
  assign req_div_quotient = req_quot_q;
  assign req_div_remain   = req_rem_q;
  assign rank_data        = rank_q;
  assign err_timeout      = err_q;

  // Weight table: writable in any state; an accept in the same cycle reads the old entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CLASS_ID_COUNT; i++) weight_q[i] <= WEIGHT_WIDTH'(1);
    end else if (cfg_wr_en) begin
      weight_q[cfg_class_id] <= cfg_weight;
    end
  end

  // Datapath next-state: descriptor capture, divider steps, request/response capture
  always_comb begin
    class_d     = class_q;
    len_d       = len_q;
    addr_d      = addr_q;
    wt_d        = wt_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    req_class_d = req_class_q;
    req_quot_d  = req_quot_q;
    req_rem_d   = req_rem_q;
    to_cnt_d    = to_cnt_q;
    err_d       = err_q;
    rank_d      = rank_q;
    case (state_q)
      S_IDLE: begin
        if (pkt_valid) begin
          class_d = pkt_class_id;
          len_d   = pkt_len;
          addr_d  = pkt_addr;
          wt_d    = wt_lookup;
          quot_d  = '0;
          rem_d   = '0;
          cnt_d   = CNT_W'(PKT_WIDTH);
        end
      end
      S_DIV: begin
        rem_d  = trial_ge ? diff[WEIGHT_WIDTH-1:0] : trial[WEIGHT_WIDTH-1:0];
        quot_d = {quot_q[PKT_WIDTH-2:0], trial_ge};
        len_d  = len_q << 1;
        cnt_d  = cnt_q - CNT_W'(1);
        // publish the finished result so the request fields are stable in ISSUE
        if (div_last) begin
          req_class_d = class_q;
          req_quot_d  = WEIGHT_WIDTH'(quot_d);
          req_rem_d   = rem_d;
        end
      end
      S_ISSUE: begin
        to_cnt_d = '0;
      end
      S_WAIT: begin
        if (resp_valid) begin
          rank_d = {resp_data[RESULT_WIDTH-1 -: RANK_HI_W], addr_q};
        end else if (timeout_hit) begin
          err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      class_q     <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      wt_q        <= WEIGHT_WIDTH'(1);
      quot_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      req_class_q <= '0;
      req_quot_q  <= '0;
      req_rem_q   <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
      rank_q      <= '0;
    end else begin
      class_q     <= class_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      wt_q        <= wt_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      req_class_q <= req_class_d;
      req_quot_q  <= req_quot_d;
      req_rem_q   <= req_rem_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
      rank_q      <= rank_d;
    end
  end

endmodule

// File: tb/tb_wfq_req_initiator.sv
// Self-checking bench for wfq_req_initiator: directed vector table,
// hand-written reset/stray-response sequences, then randomized descriptors
// checked against a plain division model of the weight table.
module tb_wfq_req_initiator;

  localparam int PW = 16;
  localparam int RT = 8;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        pkt_valid, pkt_ready;
  logic [4:0]  pkt_class_id;
  logic [15:0] pkt_len;
  logic [11:0] pkt_addr;
  logic        cfg_wr_en;
  logic [4:0]  cfg_class_id;
  logic [15:0] cfg_weight;
  logic        req_valid;
  logic [4:0]  req_class_id;
  logic [15:0] req_div_quotient, req_div_remain;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        rank_valid, rank_ready;
  logic [31:0] rank_data;
  logic        err_timeout;
  logic [2:0]  dbg_state;

  wfq_req_initiator dut (
    .clk(clk), .rst(rst),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_class_id(pkt_class_id),
    .pkt_len(pkt_len), .pkt_addr(pkt_addr),
    .cfg_wr_en(cfg_wr_en), .cfg_class_id(cfg_class_id), .cfg_weight(cfg_weight),
    .req_valid(req_valid), .req_class_id(req_class_id),
    .req_div_quotient(req_div_quotient), .req_div_remain(req_div_remain),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .rank_valid(rank_valid), .rank_ready(rank_ready), .rank_data(rank_data),
    .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // scoreboard / reference model
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];      // expected {quotient, remainder} per request
  logic [15:0] mw [32];       // model weight table
  logic        exp_err;

  typedef struct {
    logic        pre_wr;
    logic [4:0]  pre_cls;
    logic [15:0] pre_w;
    logic        same_wr;
    logic [15:0] same_w;
    logic [4:0]  cls;
    logic [15:0] len;
    logic [11:0] addr;
    logic [19:0] resp_hi;
    int          dly;         // WAIT cycles before response, -1 = never
    int          hold;        // cycles rank_ready held low
    logic [15:0] eq;
    logic [15:0] er;
  } vec_t;

  vec_t tv [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mw[i] = 16'd1;
    exp_err = 1'b0;
  endtask

  task automatic cfg_write(input logic [4:0] c, input logic [15:0] w);
    cfg_wr_en = 1'b1; cfg_class_id = c; cfg_weight = w;
    cycle();
    cfg_wr_en = 1'b0;
    mw[c] = w;
  endtask

  function automatic logic [31:0] model_div(input logic [4:0] c, input logic [15:0] len);
    logic [15:0] w;
    w = (mw[c] == 16'd0) ? 16'd1 : mw[c];
    return {len / w, len % w};
  endfunction

  // Drive one descriptor through accept, request, response and PIFO handoff.
  task automatic do_txn(input logic [4:0] cls, input logic [15:0] len, input logic [11:0] addr,
                        input logic [19:0] resp_hi, input int dly, input int hold,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic same_wr, input logic [15:0] same_w);
    int k;
    logic [31:0] e;
    logic [31:0] exp_rank;
    chk("pkt_ready_idle", pkt_ready, 1);
    exp_q.push_back({eq, er});
    exp_rank = {resp_hi, addr};
    pkt_valid = 1'b1; pkt_class_id = cls; pkt_len = len; pkt_addr = addr;
    if (same_wr) begin
      cfg_wr_en = 1'b1; cfg_class_id = cls; cfg_weight = same_w;
    end
    cycle();
    pkt_valid = 1'b0; cfg_wr_en = 1'b0;
    pkt_len = 16'($urandom); pkt_addr = 12'($urandom);
    if (same_wr) mw[cls] = same_w;
    chk("pkt_ready_busy", pkt_ready, 0);
    k = 1;
    while (!req_valid && k < 40) begin
      cycle();
      k++;
    end
    chk("req_latency", k, PW + 1);
    e = exp_q.pop_front();
    chk("req_class", req_class_id, cls);
    chk("req_quot", req_div_quotient, e[31:16]);
    chk("req_rem", req_div_remain, e[15:0]);
    cycle();
    chk("req_pulse", req_valid, 0);
    chk("req_hold_quot", req_div_quotient, e[31:16]);
    if (dly < 0) begin
      for (int i = 1; i < RT; i++) cycle();
      chk("no_early_timeout", err_timeout, exp_err);
      cycle();
      exp_err = 1'b1;
      chk("err_timeout", err_timeout, 1);
      chk("no_rank_after_to", rank_valid, 0);
      chk("ready_after_to", pkt_ready, 1);
    end else begin
      repeat (dly) cycle();
      chk("no_rank_in_wait", rank_valid, 0);
      resp_valid = 1'b1;
      resp_data = {resp_hi, 12'($urandom)};
      cycle();
      resp_valid = 1'b0;
      resp_data = $urandom;
      chk("rank_valid", rank_valid, 1);
      chk("rank_data", rank_data, exp_rank);
      for (int i = 0; i < hold; i++) begin
        rank_ready = 1'b0;
        cycle();
        chk("hold_rank_valid", rank_valid, 1);
        chk("hold_rank_data", rank_data, exp_rank);
        chk("hold_pkt_ready", pkt_ready, 0);
      end
      rank_ready = 1'b1;
      cycle();
      rank_ready = 1'b0;
      chk("rank_released", rank_valid, 0);
      chk("pkt_ready_after_rank", pkt_ready, 1);
      chk("err_sticky", err_timeout, exp_err);
    end
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] m;
    logic [4:0]  c;
    logic [15:0] l;
    logic        saw_req;

    tv[0] = '{1'b0, 5'd0, 16'd0,      1'b0, 16'd0, 5'd0, 16'hFFFF, 12'h123, {1'b1, 1'b0, 18'd3},      2, 0,  16'hFFFF, 16'd0};
    tv[1] = '{1'b1, 5'd3, 16'd7,      1'b0, 16'd0, 5'd3, 16'd100,  12'h0A5, {1'b1, 1'b0, 18'd15},     2, 0,  16'd14,   16'd2};
    tv[2] = '{1'b1, 5'd1, 16'd0,      1'b0, 16'd0, 5'd1, 16'd9,    12'h00F, {1'b1, 1'b0, 18'd77},     1, 1,  16'd9,    16'd0};
    tv[3] = '{1'b1, 5'd2, 16'd4,      1'b1, 16'd5, 5'd2, 16'd10,   12'h3C3, {1'b1, 1'b1, 18'h2AAAA},  2, 0,  16'd2,    16'd2};
    tv[4] = '{1'b0, 5'd0, 16'd0,      1'b0, 16'd0, 5'd2, 16'd10,   12'hFFF, {1'b1, 1'b0, 18'h15555},  2, 10, 16'd2,    16'd0};
    tv[5] = '{1'b0, 5'd0, 16'd0,      1'b0, 16'd0, 5'd3, 16'd100,  12'h111, {1'b1, 1'b0, 18'd1},     -1, 0,  16'd14,   16'd2};
    tv[6] = '{1'b0, 5'd0, 16'd0,      1'b0, 16'd0, 5'd3, 16'd6,    12'h222, {1'b1, 1'b1, 18'h3FFFF},  7, 0,  16'd0,    16'd6};
    tv[7] = '{1'b1, 5'd4, 16'hFFFF,   1'b0, 16'd0, 5'd4, 16'hFFFF, 12'h800, {1'b1, 1'b0, 18'd100},    0, 2,  16'd1,    16'd0};
    tv[8] = '{1'b1, 5'd5, 16'h8000,   1'b0, 16'd0, 5'd5, 16'hFFFF, 12'h001, {1'b1, 1'b0, 18'd5},      3, 0,  16'd1,    16'h7FFF};
    tv[9] = '{1'b0, 5'd0, 16'd0,      1'b0, 16'd0, 5'd5, 16'h7FFF, 12'h7FE, {1'b1, 1'b0, 18'd6},      2, 0,  16'd0,    16'h7FFF};

    rst = 1'b1;
    pkt_valid = 1'b0; pkt_class_id = '0; pkt_len = '0; pkt_addr = '0;
    cfg_wr_en = 1'b0; cfg_class_id = '0; cfg_weight = '0;
    resp_valid = 1'b0; resp_data = '0; rank_ready = 1'b0;
    model_reset();

    // reset state
    repeat (3) cycle();
    chk("rst_pkt_ready", pkt_ready, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_rank_valid", rank_valid, 0);
    chk("rst_rank_data", rank_data, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_req_quot", req_div_quotient, 0);
    rst = 1'b0;
    cycle();
    chk("post_rst_ready", pkt_ready, 1);

    // directed vector table
    for (int i = 0; i < 10; i++) begin
      if (tv[i].pre_wr) cfg_write(tv[i].pre_cls, tv[i].pre_w);
      do_txn(tv[i].cls, tv[i].len, tv[i].addr, tv[i].resp_hi, tv[i].dly, tv[i].hold,
             tv[i].eq, tv[i].er, tv[i].same_wr, tv[i].same_w);
    end

    // stray response while idle must not produce a rank
    resp_valid = 1'b1; resp_data = 32'hDEADBEEF;
    cycle();
    cycle();
    resp_valid = 1'b0;
    chk("stray_no_rank", rank_valid, 0);
    chk("stray_ready", pkt_ready, 1);
    cycle();
    chk("stray_no_rank2", rank_valid, 0);

    // reset in the fifth divide cycle discards the descriptor
    pkt_valid = 1'b1; pkt_class_id = 5'd3; pkt_len = 16'd100; pkt_addr = 12'h055;
    cycle();
    pkt_valid = 1'b0;
    repeat (4) cycle();
    rst = 1'b1;
    cycle();
    chk("midrst_pkt_ready", pkt_ready, 0);
    chk("midrst_req_valid", req_valid, 0);
    chk("midrst_rank_valid", rank_valid, 0);
    chk("midrst_rank_data", rank_data, 0);
    chk("midrst_err", err_timeout, 0);
    chk("midrst_req_quot", req_div_quotient, 0);
    chk("midrst_req_rem", req_div_remain, 0);
    chk("midrst_req_class", req_class_id, 0);
    rst = 1'b0;
    model_reset();
    saw_req = 1'b0;
    for (int i = 0; i < PW + 8; i++) begin
      cycle();
      if (req_valid) saw_req = 1'b1;
    end
    chk("midrst_no_req", saw_req, 0);
    chk("midrst_ready", pkt_ready, 1);
    // weights are back to 1 after reset
    m = model_div(5'd3, 16'd100);
    do_txn(5'd3, 16'd100, 12'h0A5, {1'b1, 1'b0, 18'd9}, 2, 0, m[31:16], m[15:0], 1'b0, 16'd0);

    // randomized descriptors against the division model
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0:       cfg_write(5'($urandom), 16'd0);
          1:       cfg_write(5'($urandom), 16'($urandom_range(1, 65535)));
          default: cfg_write(5'($urandom), 16'($urandom_range(1, 300)));
        endcase
      end
      c = 5'($urandom_range(0, 7));
      l = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 600));
      m = model_div(c, l);
      do_txn(c, l, 12'($urandom), {1'b1, 1'($urandom), 18'($urandom)},
             $urandom_range(0, RT - 1), $urandom_range(0, 3), m[31:16], m[15:0], 1'b0, 16'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wfq_req_initiator.md
Name: wfq_req_initiator

Overview:
- Initiator side of the WFQ rank-calculation interface.
- Accepts enqueue descriptors (class, packet length, buffer address) and looks up the per-class weight.
- Computes length/weight with a serial restoring divider, issues a single-cycle quotient/remainder request to the WFQ rank engine, and waits for its response.
- Splices the buffer address into the returned rank and presents it to the PIFO insert port.

Parameters:
- CLASS_WIDTH, 5: class id width; CLASS_ID_COUNT = 2**CLASS_WIDTH.
- WEIGHT_WIDTH, 16: weight, quotient and remainder width.
- PKT_WIDTH, 16: packet length width; must be <= WEIGHT_WIDTH.
- RESULT_WIDTH, 32: rank word width; equals 1+PIFO_OVERFLOW_WIDTH+PIFO_ROUND_WIDTH+PIFO_ADDR_WIDTH.
- PIFO_OVERFLOW_WIDTH, 1: overflow field width.
- PIFO_ROUND_WIDTH, 18: round field width.
- PIFO_ADDR_WIDTH, 12: buffer address field width.
- RESP_TIMEOUT, 8: maximum WAIT_RESP cycles.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pkt_valid  in  1  descriptor valid
- pkt_ready  out  1  descriptor accept; high only in IDLE
- pkt_class_id  in  CLASS_WIDTH  class of packet
- pkt_len  in  PKT_WIDTH  packet length
- pkt_addr  in  PIFO_ADDR_WIDTH  buffer address
- cfg_wr_en  in  1  weight table write strobe
- cfg_class_id  in  CLASS_WIDTH  weight table index
- cfg_weight  in  WEIGHT_WIDTH  weight value
- req_valid  out  1  engine request, one-cycle pulse
- req_class_id  out  CLASS_WIDTH  latched class
- req_div_quotient  out  WEIGHT_WIDTH  len / weight
- req_div_remain  out  WEIGHT_WIDTH  len % weight
- resp_valid  in  1  engine response strobe
- resp_data  in  RESULT_WIDTH  {1, overflow, round, addr(ignored)}
- rank_valid  out  1  rank available to PIFO
- rank_ready  in  1  PIFO accepts rank
- rank_data  out  RESULT_WIDTH  {resp_data[MSBs above addr], latched pkt_addr}
- err_timeout  out  1  sticky: engine did not respond

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - State goes to IDLE.
  - All outputs go to 0, except pkt_ready, which becomes 1 in the cycle after reset deasserts.
  - All weights reset to 1; err_timeout cleared.
  - Reset mid-operation discards the in-flight descriptor; no rank is produced.
- Weight table:
  - Written on any cycle with cfg_wr_en, in any state.
  - On accept, the weight is read and latched. A same-cycle write to the same class is not seen; the accept uses the old value.
  - Weight 0 is treated as 1.
- FSM states: IDLE, DIV, ISSUE, WAIT_RESP, OUTPUT.
  - IDLE: pkt_ready=1. On pkt_valid, latch class/len/addr/weight, clear quotient/remainder, load bit counter = PKT_WIDTH, go to DIV.
  - DIV: restoring division, one quotient bit per cycle, MSB first. rem = {rem, len[msb]}; if rem >= weight, subtract and set q bit. Runs exactly PKT_WIDTH cycles, then go to ISSUE.
  - Division width: quotient is zero-extended to WEIGHT_WIDTH; remainder is strictly < weight.
  - ISSUE: req_valid=1 for this single cycle, with class/quotient/remain stable. Next state WAIT_RESP; timeout counter cleared.
  - WAIT_RESP: on resp_valid, latch rank_data = {resp_data[RESULT_WIDTH-1:PIFO_ADDR_WIDTH], addr} and go to OUTPUT. If RESP_TIMEOUT cycles pass without resp_valid, set err_timeout and go to IDLE with no rank produced.
  - OUTPUT: rank_valid=1 and rank_data held stable until rank_ready. Go to IDLE on the cycle rank_valid&&rank_ready.
- req_class_id/quotient/remain hold their values outside ISSUE. The engine keys only on req_valid.
- resp_valid outside WAIT_RESP is ignored.
- Latency with wfq_engine attached: descriptor accepted at edge E; req_valid high in cycle E+PKT_WIDTH+1; resp_valid at E+PKT_WIDTH+4; rank_valid from E+PKT_WIDTH+5.
- Throughput: one descriptor per PKT_WIDTH+6 cycles minimum.

Test Plan:
- weight[3]=7; pkt class 3, len 100, addr 0x0A5 -> req quotient 14, remain 2. Engine response with round 15 -> rank_data {1, 0, 18'd15, 12'h0A5}, rank_valid at E+21.
- Default weight (after reset, weight 1), len 0xFFFF -> quotient 0xFFFF, remain 0. cfg weight 0 on class 1, len 9 -> quotient 9, remain 0.
- cfg_wr_en to class 2 (weight 4 -> 5) in the same cycle as an accept on class 2, len 10 -> quotient 2, remain 2. Next packet, len 10 -> quotient 2, remain 0.
- Hold rank_ready=0 for 10 cycles -> rank_valid and rank_data stable, pkt_ready=0. Raise rank_ready -> IDLE next cycle, pkt_ready=1.
- Stub engine never responds -> err_timeout=1 at ISSUE+1+RESP_TIMEOUT, no rank_valid, next descriptor accepted. Stray resp_valid in IDLE -> no effect.
- Assert rst during DIV cycle 5 -> next cycle all outputs 0, weights back to 1, no req_valid. Pkt_ready high after rst deasserts.
